// File: rtl/addertree_pkg.sv
// Shared types and constants for the adder-tree chunk sequencer slice.
// Latency: n/a (types, constants and one helper function only).
// Backpressure: n/a.
package addertree_pkg;

  localparam int NUM_ELEMENTS     = 50;
  localparam int DATA_WIDTH_float = 32;
  localparam int DATA_WIDTH_fix   = 64;
  localparam int FRAC_BITS        = 32;
  localparam int TREE_LATENCY     = 8;
  localparam int CNT_W            = 8;

  typedef logic [DATA_WIDTH_float-1:0] float_t;
  typedef logic [DATA_WIDTH_fix-1:0]   fix_t;
  typedef logic [CNT_W-1:0]            cnt_t;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} seq_state_e;

  // Integer value expressed in the Q(DATA_WIDTH_fix-FRAC_BITS).FRAC_BITS fixed format.
  function automatic fix_t int_to_fix(input int unsigned v);
    return fix_t'(v) << FRAC_BITS;
  endfunction

endpackage

// File: rtl/addertree_valid_pipe.sv
// Valid-bit delay line that mirrors the adder tree's fixed pipeline depth.
// Latency: DEPTH cycles from in_valid sample edge to out_valid sample edge.
// Backpressure: none; shifts every cycle unconditionally.
module addertree_valid_pipe
  import addertree_pkg::*;
#(
  parameter int DEPTH = TREE_LATENCY
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_valid,
  output logic out_valid
);

  logic [DEPTH-1:0] r_sr;

  // Shift one stage per cycle; reset empties the pipe so nothing stale retires.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sr <= '0;
    end else begin
      r_sr[0] <= in_valid;
      for (int i = 1; i < DEPTH; i++) begin
        r_sr[i] <= r_sr[i-1];
      end
    end
  end

  assign out_valid = r_sr[DEPTH-1];

endmodule

// File: rtl/addertree_chunk_sequencer.sv
// Feeds NUM_ELEMENTS-wide float chunks to a shared adder tree and accumulates its fixed-point sums.
// Latency: result_valid rises TREE_LATENCY+1 cycles after the last chunk is accepted.
// Backpressure: chunk_ready is a pure state decode; result is held until result_ready.
module addertree_chunk_sequencer
  import addertree_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   start,
  input  cnt_t   num_chunks,
  output logic   busy,
  input  logic   chunk_valid,
  output logic   chunk_ready,
  input  float_t chunk_data [NUM_ELEMENTS],
  output float_t tree_in    [NUM_ELEMENTS],
  input  fix_t   tree_out,
  output logic   result_valid,
  input  logic   result_ready,
  output fix_t   result,
  output logic   overflow
);

  seq_state_e r_state;
  seq_state_e w_state_nxt;
  cnt_t       r_num;
  cnt_t       r_issued;
  cnt_t       r_retired;
  fix_t       r_acc;
  fix_t       r_result;
  logic       r_ovf;
  float_t     r_tree_in [NUM_ELEMENTS];

  logic w_chunk_ready;
  logic w_accept;
  logic w_retire;
  cnt_t w_issued_nxt;
  cnt_t w_retired_nxt;
  fix_t w_sum;
  logic w_add_ovf;

  assign w_issued_nxt  = r_issued + cnt_t'(1);
  assign w_retired_nxt = r_retired + cnt_t'(1);
  assign w_sum         = r_acc + tree_out;
  // Signed overflow: operands agree in sign but the wrapped sum does not.
  assign w_add_ovf     = (r_acc[DATA_WIDTH_fix-1] == tree_out[DATA_WIDTH_fix-1]) &&
                         (w_sum[DATA_WIDTH_fix-1] != r_acc[DATA_WIDTH_fix-1]);

  addertree_valid_pipe #(.DEPTH(TREE_LATENCY)) u_valid_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (w_accept),
    .out_valid (w_retire)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state and handshake decode; chunk_ready never looks at chunk_valid.
  always_comb begin
    w_state_nxt   = r_state;
    w_chunk_ready = 1'b0;
    w_accept      = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) w_state_nxt = (num_chunks != '0) ? ISSUE : DONE;
      end
      ISSUE: begin
        w_chunk_ready = (r_issued < r_num);
        w_accept      = w_chunk_ready && chunk_valid;
        if (w_accept && (w_issued_nxt == r_num)) w_state_nxt = DRAIN;
      end
      DRAIN: begin
        if (w_retire && (w_retired_nxt == r_num)) w_state_nxt = DONE;
      end
      DONE: begin
        if (result_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Job setup, chunk issue, retire accumulation and final result capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_num     <= '0;
      r_issued  <= '0;
      r_retired <= '0;
      r_acc     <= '0;
      r_result  <= '0;
      r_ovf     <= 1'b0;
      for (int i = 0; i < NUM_ELEMENTS; i++) r_tree_in[i] <= '0;
    end else begin
      if ((r_state == IDLE) && start) begin
        r_num     <= num_chunks;
        r_issued  <= '0;
        r_retired <= '0;
        r_acc     <= '0;
        r_ovf     <= 1'b0;
        if (num_chunks == '0) r_result <= '0;
      end
      if (w_accept) begin
        r_tree_in <= chunk_data;
        r_issued  <= w_issued_nxt;
      end
      if (w_retire) begin
        r_acc     <= w_sum;
        r_retired <= w_retired_nxt;
        if (w_add_ovf) r_ovf <= 1'b1;
      end
      if ((r_state == DRAIN) && (w_state_nxt == DONE)) r_result <= w_sum;
    end
  end

  assign busy         = (r_state != IDLE);
  assign chunk_ready  = w_chunk_ready;
  assign result_valid = (r_state == DONE);
  assign result       = r_result;
  assign overflow     = r_ovf;
  assign tree_in      = r_tree_in;

endmodule

// File: doc/addertree_chunk_sequencer.md
Name: addertree_chunk_sequencer

Overview:
- Sequences a long float vector, delivered as NUM_ELEMENTS-wide chunks, through one shared AdderTree_FloatToFixed instance.
- Registers each accepted chunk onto the tree inputs and tracks the tree's fixed pipeline latency with a valid shift register.
- Accumulates the 64-bit fixed-point partial sums and returns the total through a valid/ready result handshake.
- Sits between the feature-vector buffer and the adder tree in the 3D-face datapath.

Parameters:
- NUM_ELEMENTS, 50: floats per chunk; equals the tree input count.
- DATA_WIDTH_float, 32: IEEE-754 single-precision element width.
- DATA_WIDTH_fix, 64: fixed-point tree output and accumulator width, two's complement.
- FRAC_BITS, 32: fractional bits of the fixed format (Q32.32).
- TREE_LATENCY, 8: cycles from the tree_in register update to the matching tree_out sample edge; must be at least 1.
- CNT_W, 8: chunk counter width; at most 2^CNT_W-1 chunks per job.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle job start pulse; honoured only in IDLE.
- num_chunks  in  CNT_W  chunk count for the job; sampled on start.
- busy  out  1  high in every state except IDLE.
- chunk_valid  in  1  chunk_data is valid.
- chunk_ready  out  1  sequencer accepts a chunk this cycle.
- chunk_data  in  DATA_WIDTH_float x NUM_ELEMENTS  unpacked array of chunk elements.
- tree_in  out  DATA_WIDTH_float x NUM_ELEMENTS  registered array driving the adder tree.
- tree_out  in  DATA_WIDTH_fix  adder tree result.
- result_valid  out  1  result is valid; held until accepted.
- result_ready  in  1  consumer accepts the result.
- result  out  DATA_WIDTH_fix  accumulated sum.
- overflow  out  1  sticky signed-overflow flag for the current job.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy, chunk_ready, result_valid and overflow =0; result, accumulator and all counters =0; valid shift register cleared; tree_in cleared to 0. Reset mid-job abandons the job; no stale retire ever reaches the accumulator.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - On start with num_chunks>0: latch num_chunks; clear accumulator, overflow, issued and retired counters; go to ISSUE.
  - On start with num_chunks=0: clear result and overflow; go to DONE (result=0).
- ISSUE:
  - chunk_ready = (issued < num_chunks). It is a registered-state decode and never depends on chunk_valid.
  - Accept on chunk_valid & chunk_ready at edge k: tree_in <= chunk_data; issued++; a 1 enters the valid shift register.
  - When the final chunk is accepted, go to DRAIN on the same edge.
- Valid shift register:
  - Depth TREE_LATENCY; it shifts every cycle in every state.
  - Its output bit high at edge k+TREE_LATENCY marks a retire: acc <= acc + tree_out; retired++.
  - Issue and retire on the same edge are both performed.
- Accumulation:
  - Full DATA_WIDTH_fix wrap-around addition; no saturation.
  - overflow is set when both operands share a sign and the sum's sign differs; it stays set until the next start.
- DRAIN: chunk_ready=0. When the retire edge makes retired equal num_chunks, go to DONE and load result <= the final sum on that same edge.
- DONE: result_valid=1 and result is held stable while result_valid & !result_ready. On result_ready, drop result_valid and go to IDLE on that edge. result keeps its value afterwards.
- start outside IDLE is ignored. chunk_valid outside ISSUE is ignored.
- Latency:
  - Single chunk: result_valid rises one cycle after the retire edge, i.e. TREE_LATENCY+1 cycles after acceptance.
  - N chunks back-to-back: last acceptance + TREE_LATENCY + 1.
- Throughput: one chunk per cycle with no bubbles.

Decomposition:
- Shared package addertree_pkg:
  - float_t (logic [DATA_WIDTH_float-1:0]) and fix_t (logic [DATA_WIDTH_fix-1:0]).
  - NUM_ELEMENTS, TREE_LATENCY and FRAC_BITS constants.
  - seq_state_e enum {IDLE, ISSUE, DRAIN, DONE}.
- One sub-module: addertree_valid_pipe, a TREE_LATENCY-deep async-reset valid shift register with in_valid/out_valid. Everything else stays in the top level.

Test Plan:
- Single chunk: start, num_chunks=1, all elements 32'h3F800000 (1.0), tree model returns 0x0000_0032_0000_0000 -> result=0x0000_0032_0000_0000 (50.0); result_valid rises exactly TREE_LATENCY+1 cycles after acceptance; overflow=0.
- Back-to-back 4 chunks: all elements 3.0 (32'h40400000), chunk_valid held high -> chunk_ready high for exactly 4 cycles; result=0x0000_0258_0000_0000 (600.0).
- Gapped input and stalled output: 3 chunks with chunk_valid low 2 cycles between them, then result_ready held low 5 cycles -> result and result_valid stable for all 5 cycles; IDLE entered on the handshake edge.
- num_chunks=0 -> DONE the cycle after start, result=0, chunk_ready never asserted.
- Overflow: 2 chunks, tree model forces 0x7FFF_FFFF_0000_0000 twice -> result wraps to 0xFFFF_FFFE_0000_0000; overflow=1, then cleared on the next start.
- Reset mid-DRAIN: rst_n low 1 cycle with 2 retires pending -> all outputs at reset values immediately; a new 1-chunk job then gives the correct sum with no stale accumulation.
